stretch_pulse_multi: RTL

//  Multi-channel minimum-width pulse stretcher for LED/status indicators and slow observers of fast events.

---
 rtl/stretch_pulse_multi.sv | 98 +++++++++
 1 files changed

// File: rtl/stretch_pulse_multi.sv
// stretch_pulse_multi: multi-channel minimum-width pulse stretcher.
// Each channel turns an accepted active edge into an output that stays high
// for at least STRETCH_CYCLES clocks, with per-channel polarity and enable.
// Optional build macro STRETCH_PULSE_MULTI_SYNC_EN inserts a two-flop
// synchroniser per channel ahead of the polarity/edge logic (+2 clocks latency).
// Handshake: none; every output is a plain level or one-cycle strobe per clock.
module stretch_pulse_multi #(
  parameter int                  CHANNELS       = 4,
  parameter int                  SYSTEM_CLOCK   = 50000000,
  parameter int                  STRETCH_CYCLES = SYSTEM_CLOCK / 10,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW     = {CHANNELS{1'b0}},
  parameter int                  RETRIGGER      = 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [CHANNELS-1:0] in_i,
  input  logic [CHANNELS-1:0] enable_i,
  output logic [CHANNELS-1:0] out_o,
  output logic [CHANNELS-1:0] active_o,
  output logic [CHANNELS-1:0] edge_o
);

  localparam int            CW     = $clog2(STRETCH_CYCLES);
  // Counter holds STRETCH_CYCLES-2: one clock is covered by the detected
  // edge itself and one by the act term, so the output totals STRETCH_CYCLES.
  localparam logic [CW-1:0] RELOAD = CW'(STRETCH_CYCLES - 2);
  localparam logic [CW-1:0] ONE    = CW'(1);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic          act;
    logic [1:0]    hist;
    logic          det;
    logic [CW-1:0] cnt;
    logic          out_q;
    logic          edge_q;

`ifdef STRETCH_PULSE_MULTI_SYNC_EN
    logic sync1;
    logic sync2;

    // Two-flop synchroniser; resets to the raw inactive level of the channel
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        sync1 <= ACTIVE_LOW[c];
        sync2 <= ACTIVE_LOW[c];
      end else begin
        sync1 <= in_i[c];
        sync2 <= sync1;
      end
    end

    assign act = sync2 ^ ACTIVE_LOW[c];
`else
    assign act = in_i[c] ^ ACTIVE_LOW[c];
`endif

    // Rising edge of the normalised input: previous sample low, latest high
    assign det = (hist == 2'b01);

    // Edge history; keeps tracking while disabled so re-enable sees no stale edge
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
`ifdef STRETCH_PULSE_MULTI_SYNC_EN
        hist <= 2'b00;
`else
        hist <= {act, act};
`endif
      end else begin
        hist <= {hist[0], act};
      end
    end

    // Stretch counter, stretched output and accepted-edge strobe
    always_ff @(posedge clk_i) begin
      if (reset_i || !enable_i[c]) begin
        cnt    <= '0;
        out_q  <= 1'b0;
        edge_q <= 1'b0;
      end else begin
        out_q <= (cnt != '0) | act | det;
        if (det && ((cnt == '0) || (RETRIGGER != 0))) begin
          cnt    <= RELOAD;
          edge_q <= 1'b1;
        end else begin
          edge_q <= 1'b0;
          if (cnt != '0) begin
            cnt <= cnt - ONE;
          end
        end
      end
    end

    assign out_o[c]    = out_q;
    assign edge_o[c]   = edge_q;
    assign active_o[c] = (cnt != '0);
  end

endmodule
